// File: rtl/tl_tag_table.sv
// Tag table for outstanding non-posted reads: allocates tags round-robin from a
// search pointer, stores request metadata, and serves zero-latency lookups.
module tl_tag_table #(
  parameter int TAG_W    = 8,
  parameter int NUM_TAGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_i,
  input  logic [15:0]       alloc_req_id_i,
  input  logic [31:0]       alloc_addr_i,
  input  logic [9:0]        alloc_len_i,
  input  logic [2:0]        alloc_attr_i,
  output logic              alloc_ready_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  input  logic              lookup_valid_i,
  output logic              lookup_ready_o,
  output logic [15:0]       lookup_req_id_o,
  output logic [31:0]       lookup_addr_o,
  output logic [9:0]        lookup_len_o,
  output logic [2:0]        lookup_attr_o,
  output logic              lookup_hit_o,
  input  logic [TAG_W-1:0]  free_tag_i,
  input  logic              free_valid_i,
  output logic [TAG_W:0]    inflight_cnt_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);
  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [IDX_W:0] NT_I   = (IDX_W+1)'(NUM_TAGS);
  localparam logic [IDX_W:0] LAST_I = (IDX_W+1)'(NUM_TAGS-1);
  localparam logic [TAG_W:0] NT_T   = (TAG_W+1)'(NUM_TAGS);

  typedef struct packed {
    logic [15:0] req_id;
    logic [31:0] addr;
    logic [9:0]  len;
    logic [2:0]  attr;
  } meta_t;

  logic [NUM_TAGS-1:0] busy;
  meta_t               meta [NUM_TAGS];
  logic [IDX_W-1:0]    nxt_ptr;
  logic [IDX_W-1:0]    grant;
  logic                found;
  logic [TAG_W:0]      cnt;
  logic                err;

  // Rotating first-idle search starting at nxt_ptr. busy is registered, so a
  // tag released this cycle still looks busy and cannot be re-granted yet.
  always_comb begin
    logic [IDX_W:0] jj;
    found = 1'b0;
    grant = '0;
    jj    = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      jj = {1'b0, nxt_ptr} + (IDX_W+1)'(i);
      if (jj >= NT_I) jj = jj - NT_I;
      if (!found && !busy[jj[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = jj[IDX_W-1:0];
      end
    end
  end

  logic             do_alloc;
  logic             fr_in, free_ok, free_bad;
  logic [IDX_W-1:0] fr_idx;

  assign alloc_ready_o = found & ~rst;
  assign alloc_tag_o   = TAG_W'(grant);
  assign do_alloc      = alloc_valid_i & alloc_ready_o;

  assign fr_in    = {1'b0, free_tag_i} < NT_T;
  assign fr_idx   = free_tag_i[IDX_W-1:0];
  assign free_ok  = free_valid_i & fr_in & busy[fr_idx];
  assign free_bad = free_valid_i & ~free_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      nxt_ptr <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (do_alloc) begin
        busy[grant] <= 1'b1;
        nxt_ptr     <= ({1'b0, grant} == LAST_I) ? '0 : grant + IDX_W'(1);
      end
      // A granted tag is always idle and a freed one always busy, so the two
      // bit updates never collide.
      if (free_ok)  busy[fr_idx] <= 1'b0;
      if (free_bad) err <= 1'b1;
      case ({do_alloc, free_ok})
        2'b10:   cnt <= cnt + (TAG_W+1)'(1);
        2'b01:   cnt <= cnt - (TAG_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc)
      meta[grant] <= '{req_id: alloc_req_id_i, addr: alloc_addr_i,
                       len: alloc_len_i, attr: alloc_attr_i};
  end

  logic             lk_in;
  logic [IDX_W-1:0] lk_idx;
  meta_t            lk;

  assign lk_in        = {1'b0, lookup_tag_i} < NT_T;
  assign lk_idx       = lookup_tag_i[IDX_W-1:0];
  assign lookup_hit_o = lookup_valid_i & ~rst & lk_in & busy[lk_idx];
  assign lk           = lookup_hit_o ? meta[lk_idx] : '0;

  assign lookup_ready_o  = 1'b1;
  assign lookup_req_id_o = lk.req_id;
  assign lookup_addr_o   = lk.addr;
  assign lookup_len_o    = lk.len;
  assign lookup_attr_o   = lk.attr;

  assign inflight_cnt_o = cnt;
  assign full_o         = ~rst & (cnt == NT_T);
  assign empty_o        = rst | (cnt == '0);
  assign err_o          = err;
endmodule

// File: tb/tb_tl_tag_table.sv
// Directed bench for tl_tag_table: allocation order, lookup timing, free errors,
// full/empty boundaries and mid-operation reset.
module tb_tl_tag_table;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid_i;
  logic [15:0] alloc_req_id_i;
  logic [31:0] alloc_addr_i;
  logic [9:0]  alloc_len_i;
  logic [2:0]  alloc_attr_i;
  logic        alloc_ready_o;
  logic [7:0]  alloc_tag_o;
  logic [7:0]  lookup_tag_i;
  logic        lookup_valid_i;
  logic        lookup_ready_o;
  logic [15:0] lookup_req_id_o;
  logic [31:0] lookup_addr_o;
  logic [9:0]  lookup_len_o;
  logic [2:0]  lookup_attr_o;
  logic        lookup_hit_o;
  logic [7:0]  free_tag_i;
  logic        free_valid_i;
  logic [8:0]  inflight_cnt_o;
  logic        full_o, empty_o, err_o;

  int n_chk  = 0;
  int n_fail = 0;

  tl_tag_table #(.TAG_W(8), .NUM_TAGS(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_req_id_i(alloc_req_id_i),
    .alloc_addr_i(alloc_addr_i), .alloc_len_i(alloc_len_i),
    .alloc_attr_i(alloc_attr_i), .alloc_ready_o(alloc_ready_o),
    .alloc_tag_o(alloc_tag_o), .lookup_tag_i(lookup_tag_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_req_id_o(lookup_req_id_o), .lookup_addr_o(lookup_addr_o),
    .lookup_len_o(lookup_len_o), .lookup_attr_o(lookup_attr_o),
    .lookup_hit_o(lookup_hit_o), .free_tag_i(free_tag_i),
    .free_valid_i(free_valid_i), .inflight_cnt_o(inflight_cnt_o),
    .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Metadata is derived from the address so lookups can be predicted by hand.
  task automatic set_meta(input logic [31:0] a);
    alloc_addr_i   = a;
    alloc_req_id_i = a[31:16] ^ a[15:0];
    alloc_len_i    = a[21:12];
    alloc_attr_i   = a[14:12];
  endtask

  task automatic alloc(input logic [31:0] a, input int exp_tag);
    @(negedge clk);
    alloc_valid_i = 1'b1;
    set_meta(a);
    #1;
    chk("alloc_ready", 32'(alloc_ready_o), 1);
    chk("alloc_tag", 32'(alloc_tag_o), 32'(exp_tag));
    @(posedge clk); #1;
    alloc_valid_i = 1'b0;
  endtask

  task automatic free(input logic [7:0] t);
    @(negedge clk);
    free_valid_i = 1'b1;
    free_tag_i   = t;
    @(posedge clk); #1;
    free_valid_i = 1'b0;
  endtask

  task automatic look(input logic [7:0] t, input logic exp_hit, input logic [31:0] exp_addr);
    @(negedge clk);
    lookup_valid_i = 1'b1;
    lookup_tag_i   = t;
    #1;
    chk("lookup_hit", 32'(lookup_hit_o), 32'(exp_hit));
    chk("lookup_addr", lookup_addr_o, exp_addr);
    chk("lookup_req_id", 32'(lookup_req_id_o),
        32'(exp_hit ? (exp_addr[31:16] ^ exp_addr[15:0]) : 16'h0));
    lookup_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic status(input int exp_cnt, input logic exp_err);
    @(negedge clk); #1;
    chk("inflight_cnt", 32'(inflight_cnt_o), 32'(exp_cnt));
    chk("err", 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid_i = 1'b0; free_valid_i = 1'b0; lookup_valid_i = 1'b0;
    free_tag_i = '0; lookup_tag_i = '0;
    set_meta(32'h0);

    // Strobes during reset must be ignored.
    @(negedge clk);
    alloc_valid_i = 1'b1; free_valid_i = 1'b1; free_tag_i = 8'd0;
    lookup_valid_i = 1'b1; lookup_tag_i = 8'd0;
    #1;
    chk("rst_ready", 32'(alloc_ready_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_hit", 32'(lookup_hit_o), 0);
    chk("lookup_ready", 32'(lookup_ready_o), 1);
    @(posedge clk); #1;
    rst = 1'b0; alloc_valid_i = 1'b0; free_valid_i = 1'b0; lookup_valid_i = 1'b0;
    status(0, 1'b0);
    chk("post_rst_empty", 32'(empty_o), 1);
    chk("post_rst_tag", 32'(alloc_tag_o), 0);

    // Back-to-back allocs; lookup in the alloc cycle misses.
    @(negedge clk);
    alloc_valid_i = 1'b1; set_meta(32'h1000);
    lookup_valid_i = 1'b1; lookup_tag_i = 8'd0;
    #1;
    chk("alloc_tag0", 32'(alloc_tag_o), 0);
    chk("same_cycle_miss", 32'(lookup_hit_o), 0);
    @(posedge clk); #1;
    alloc_valid_i = 1'b0; lookup_valid_i = 1'b0;
    alloc(32'h2000, 1);
    alloc(32'h3000, 2);
    status(3, 1'b0);
    look(8'd0, 1'b1, 32'h1000);
    look(8'd1, 1'b1, 32'h2000);
    @(negedge clk);
    lookup_valid_i = 1'b1; lookup_tag_i = 8'd1;
    #1;
    chk("len1", 32'(lookup_len_o), 32'h002);
    chk("attr1", 32'(lookup_attr_o), 32'h2);
    // Lookup and free of the same tag: hit with pre-free contents.
    free_valid_i = 1'b1; free_tag_i = 8'd1;
    #1;
    chk("lookup_during_free", 32'(lookup_hit_o), 1);
    chk("addr_during_free", lookup_addr_o, 32'h2000);
    @(posedge clk); #1;
    free_valid_i = 1'b0; lookup_valid_i = 1'b0;
    look(8'd1, 1'b0, 32'h0);
    status(2, 1'b0);

    // Same-cycle alloc and free; len 0 stored verbatim.
    do_reset();
    alloc(32'h0040_0000, 0);
    alloc(32'h5000, 1);
    @(negedge clk);
    lookup_valid_i = 1'b1; lookup_tag_i = 8'd0;
    #1;
    chk("len_zero", 32'(lookup_len_o), 0);
    chk("len_zero_hit", 32'(lookup_hit_o), 1);
    lookup_valid_i = 1'b0;
    alloc_valid_i = 1'b1; set_meta(32'h6000);
    free_valid_i = 1'b1; free_tag_i = 8'd0;
    #1;
    chk("alloc_free_tag", 32'(alloc_tag_o), 2);
    @(posedge clk); #1;
    alloc_valid_i = 1'b0; free_valid_i = 1'b0;
    status(2, 1'b0);
    look(8'd0, 1'b0, 32'h0);
    look(8'd2, 1'b1, 32'h6000);

    // Pointer rotation, wrap, full, and release of a tag from full.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'(i + 1) << 12, i);
    free(8'd1);
    alloc(32'h0005_0000, 4);
    for (int i = 5; i < 32; i++) alloc(32'(i + 1) << 12, i);
    alloc(32'h0077_0000, 1);
    status(32, 1'b0);
    chk("full", 32'(full_o), 1);
    chk("full_ready", 32'(alloc_ready_o), 0);
    @(negedge clk);
    free_valid_i = 1'b1; free_tag_i = 8'd5;
    #1;
    chk("freed_not_granted", 32'(alloc_ready_o), 0);
    @(posedge clk); #1;
    free_valid_i = 1'b0;
    status(31, 1'b0);
    chk("refree_ready", 32'(alloc_ready_o), 1);
    chk("refree_tag", 32'(alloc_tag_o), 5);
    chk("refree_full", 32'(full_o), 0);

    // Illegal frees: idle tag, then out-of-range tag; err is sticky.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'(i + 1) << 12, i);
    free(8'd7);
    status(4, 1'b1);
    free(8'd40);
    status(4, 1'b1);
    status(4, 1'b1);
    look(8'd7, 1'b0, 32'h0);
    look(8'd40, 1'b0, 32'h0);

    // Reset mid-operation discards tags and clears err.
    do_reset();
    for (int i = 0; i < 10; i++) alloc(32'(i + 1) << 12, i);
    free(8'd20);
    status(10, 1'b1);
    @(negedge clk);
    rst = 1'b1; alloc_valid_i = 1'b1; free_valid_i = 1'b1; free_tag_i = 8'd3;
    #1;
    chk("mid_rst_ready", 32'(alloc_ready_o), 0);
    chk("mid_rst_empty", 32'(empty_o), 1);
    @(posedge clk); #1;
    rst = 1'b0; alloc_valid_i = 1'b0; free_valid_i = 1'b0;
    status(0, 1'b0);
    chk("mid_rst_empty_after", 32'(empty_o), 1);
    look(8'd3, 1'b0, 32'h0);
    alloc(32'h9000, 0);
    status(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tl_tag_table.md
TL_TAG_TABLE -- requirements
Module: tl_tag_table

Interface
REQ-001 Parameter TAG_W, default 8, width of tag fields.
REQ-002 Parameter NUM_TAGS, default 32, number of tracked tags (0..NUM_TAGS-1); legal range 2..2**TAG_W.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 alloc_valid_i  in  1  request side wants a tag for a new non-posted read.
REQ-006 alloc_req_id_i / alloc_addr_i / alloc_len_i / alloc_attr_i  in  16/32/10/3  metadata stored with the tag.
REQ-007 alloc_ready_o  out  1  a free tag exists and the table can accept.
REQ-008 alloc_tag_o  out  TAG_W  tag granted on the alloc handshake.
REQ-009 lookup_tag_i  in  TAG_W  tag queried by the completion engine.
REQ-010 lookup_valid_i  in  1  lookup strobe.
REQ-011 lookup_ready_o  out  1  constant 1; lookup is combinational.
REQ-012 lookup_req_id_o / lookup_addr_o / lookup_len_o / lookup_attr_o  out  16/32/10/3  stored metadata for lookup_tag_i.
REQ-013 lookup_hit_o  out  1  lookup_valid_i and the tag is in range and busy.
REQ-014 free_tag_i  in  TAG_W  tag to release; free_valid_i  in  1  release strobe, single-cycle, no ready.
REQ-015 inflight_cnt_o  out  TAG_W+1  number of busy tags.
REQ-016 full_o / empty_o  out  1/1  count == NUM_TAGS / count == 0.
REQ-017 err_o  out  1  sticky: free of idle or out-of-range tag.

Function
REQ-018 Each tag SHALL hold a busy bit plus req_id, addr, len, attr.
REQ-019 alloc_ready_o SHALL be 1 iff at least one busy bit is 0 and rst is low.
REQ-020 alloc_tag_o SHALL be the first idle tag found searching upward, with wrap, from search pointer nxt_ptr; the value SHALL be combinationally valid while alloc_ready_o=1.
REQ-021 On alloc_valid_i && alloc_ready_o, the table SHALL set busy[alloc_tag_o], store the metadata, and set nxt_ptr to alloc_tag_o+1, wrapping NUM_TAGS-1 -> 0.
REQ-022 alloc_valid_i SHALL NOT be required to wait for alloc_ready_o; alloc_tag_o SHALL NOT depend on alloc_valid_i.
REQ-023 Lookup SHALL have zero latency: outputs reflect registered table contents in the same cycle; fields SHALL be 0 when lookup_hit_o=0.
REQ-024 A lookup of a tag allocated in the current cycle SHALL miss; it SHALL hit from the next cycle.
REQ-025 On free_valid_i with a busy, in-range tag, the table SHALL clear busy next edge; metadata MAY remain stale.
REQ-026 On free_valid_i with an idle or out-of-range tag (>= NUM_TAGS), the table SHALL leave state unchanged and set err_o.
REQ-027 Same-cycle alloc and free SHALL both take effect; count is unchanged; a tag freed this cycle SHALL NOT be granted this cycle.
REQ-028 inflight_cnt_o SHALL be registered: +1 on alloc only, -1 on valid free only, unchanged on both or neither; it SHALL never exceed NUM_TAGS or underflow.
REQ-029 A lookup and a free of the same tag in the same cycle SHALL hit with the pre-free contents.
REQ-030 alloc_len_i SHALL be stored verbatim; 0 encodes 1024 DW and the table SHALL NOT reinterpret it.

Reset
REQ-031 While rst=1 at an edge, the table SHALL clear all busy bits, clear nxt_ptr, clear inflight_cnt_o, and clear err_o.
REQ-032 Metadata storage SHALL NOT need reset.
REQ-033 During rst=1, alloc_ready_o=0, lookup_hit_o=0, empty_o=1, full_o=0.
REQ-034 Reset asserted mid-operation SHALL discard all outstanding tags; the first grant after reset SHALL be tag 0.
REQ-035 alloc/free inputs seen in a cycle with rst=1 SHALL be ignored.

Verification
REQ-036 Reset, then 3 back-to-back allocs with addr 0x1000/0x2000/0x3000 -> tags 0,1,2; inflight_cnt_o=3; lookup tag 1 -> hit, addr 0x2000.
REQ-037 32 allocs with NUM_TAGS=32 -> full_o=1, alloc_ready_o=0; free tag 5 -> next cycle alloc_ready_o=1 and alloc_tag_o=5.
REQ-038 Allocate tags 0..3, free tag 1, allocate again -> tag 4 (pointer rotation); tag 1 is not reused until the pointer wraps.
REQ-039 Same-cycle alloc (grants tag 2) and free of tag 0 -> count unchanged; tag 0 idle and tag 2 busy next cycle.
REQ-040 Free idle tag 7, then free tag 40 -> err_o=1 and stays 1; inflight_cnt_o unchanged; lookup tag 7 -> hit=0 with fields 0.
REQ-041 Assert rst with 10 tags busy -> next cycle inflight_cnt_o=0, err_o=0, empty_o=1; first grant after rst drops is tag 0.
